// File: rtl/toom_pkg.sv
// toom_pkg: shared state encoding, point schedule and default sizes for the Toom-K evaluator.
package toom_pkg;
  localparam int TOOM_CHUNK_W    = 129;
  localparam int TOOM_NUM_CHUNKS = 8;
  localparam int TOOM_OUT_W      = 155;
  localparam int TOOM_XW         = 5;
  typedef enum logic [1:0] {IDLE, HORNER, EMIT} state_e;
  typedef struct packed {
    logic               is_inf;
    logic signed [31:0] x;
  } point_t;
  // Order 0, 1, -1, 2, -2, ... with the last finite point forced to -(k-1), then inf.
  function automatic point_t point_x(input int i, input int k);
    point_t p;
    p.is_inf = i == 2 * k - 2;
    p.x = (i == 0 || p.is_inf) ? 0 : (i == 2 * k - 3) ? -(k - 1) : (i % 2 == 1) ? (i + 1) / 2 : -(i / 2);
    return p;
  endfunction
endpackage

// File: rtl/toom_horner_mac.sv
// toom_horner_mac: one Horner step, res = acc * x + chunk (chunk zero-extended), signed, single cycle.
module toom_horner_mac #(
  parameter int AW      = 155,
  parameter int CHUNK_W = 129,
  parameter int XW      = 5
) (
  input  logic signed [AW-1:0]      acc_i,
  input  logic signed [XW-1:0]      x_i,
  input  logic        [CHUNK_W-1:0] chunk_i,
  output logic signed [AW-1:0]      res_o
);
  logic signed [AW-1:0] x_ext;
  assign x_ext = AW'(x_i);
  assign res_o = acc_i * x_ext + $signed(AW'(chunk_i));
endmodule

// File: rtl/toom_eval_seq.sv
// toom_eval_seq: sequential Toom-K evaluator streaming A(x), B(x) at all 2K-1 points via shared Horner MACs.
// Optional sticky overflow flag on port ovf when TOOM_EVAL_OVF_CHK_EN is defined.
module toom_eval_seq
  import toom_pkg::*;
#(
  parameter int CHUNK_W    = TOOM_CHUNK_W,
  parameter int NUM_CHUNKS = TOOM_NUM_CHUNKS,
  parameter int OUT_W      = TOOM_OUT_W,
  parameter int XW         = TOOM_XW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CHUNKS*CHUNK_W-1:0]       a_chunks,
  input  logic [NUM_CHUNKS*CHUNK_W-1:0]       b_chunks,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(2*NUM_CHUNKS-1)-1:0]   out_idx,
  output logic signed [OUT_W-1:0]             out_a,
  output logic signed [OUT_W-1:0]             out_b,
  output logic                                out_last
`ifdef TOOM_EVAL_OVF_CHK_EN
  ,
  output logic                                ovf
`endif
);
  localparam int NP  = 2 * NUM_CHUNKS - 1;
  localparam int IW  = $clog2(NP);
  localparam int KW  = $clog2(NUM_CHUNKS);
  localparam int TOP = (NUM_CHUNKS - 1) * CHUNK_W;
`ifdef TOOM_EVAL_OVF_CHK_EN
  localparam int AW = OUT_W + XW + 1;
`else
  localparam int AW = OUT_W;
`endif
  state_e                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [KW-1:0]                   step_q, step_d;
  logic [NUM_CHUNKS*CHUNK_W-1:0]   a_q, b_q;
  logic signed [AW-1:0]            acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic signed [AW-1:0]            seed_a, seed_b, mac_a, mac_b;
  logic signed [XW-1:0]            x;
  point_t                          pt;
  logic                            unused_px;
  logic                            accept;
  int                              cidx;
  assign pt        = point_x(int'(idx_q), NUM_CHUNKS);
  assign x         = pt.x[XW-1:0];
  assign unused_px = ^pt.x[31:XW];
  assign in_ready  = state_q == IDLE && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == EMIT && !rst;
  assign out_last  = out_valid && pt.is_inf;
  assign out_idx   = idx_q;
  assign out_a     = acc_a_q[OUT_W-1:0];
  assign out_b     = acc_b_q[OUT_W-1:0];
  // The first Horner step seeds from the top chunk; later steps feed back the accumulator.
  assign cidx   = NUM_CHUNKS - 2 - int'(step_q);
  assign seed_a = step_q == '0 ? AW'(a_q[TOP +: CHUNK_W]) : acc_a_q;
  assign seed_b = step_q == '0 ? AW'(b_q[TOP +: CHUNK_W]) : acc_b_q;
  toom_horner_mac #(.AW(AW), .CHUNK_W(CHUNK_W), .XW(XW)) u_mac_a (
    .acc_i   (seed_a),
    .x_i     (x),
    .chunk_i (a_q[cidx*CHUNK_W +: CHUNK_W]),
    .res_o   (mac_a)
  );
  toom_horner_mac #(.AW(AW), .CHUNK_W(CHUNK_W), .XW(XW)) u_mac_b (
    .acc_i   (seed_b),
    .x_i     (x),
    .chunk_i (b_q[cidx*CHUNK_W +: CHUNK_W]),
    .res_o   (mac_b)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = EMIT;
        idx_d   = '0;
        acc_a_d = AW'(a_chunks[CHUNK_W-1:0]);
        acc_b_d = AW'(b_chunks[CHUNK_W-1:0]);
      end
      HORNER: begin
        acc_a_d = mac_a;
        acc_b_d = mac_b;
        step_d  = step_q == KW'(NUM_CHUNKS - 2) ? '0 : step_q + 1'b1;
        state_d = step_q == KW'(NUM_CHUNKS - 2) ? EMIT : HORNER;
      end
      EMIT: if (out_ready) begin
        idx_d   = idx_q == IW'(NP - 1) ? '0 : idx_q + 1'b1;
        state_d = idx_q == IW'(NP - 1) ? IDLE : idx_q == IW'(NP - 2) ? EMIT : HORNER;
        // A(inf) is simply the top chunk, so it skips the Horner pass.
        acc_a_d = idx_q == IW'(NP - 2) ? AW'(a_q[TOP +: CHUNK_W]) : acc_a_q;
        acc_b_d = idx_q == IW'(NP - 2) ? AW'(b_q[TOP +: CHUNK_W]) : acc_b_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a_chunks;
      b_q <= b_chunks;
    end
  end
`ifdef TOOM_EVAL_OVF_CHK_EN
  logic ovf_q;
  function automatic logic out_of_range(input logic signed [AW-1:0] v);
    return v != {{(AW-OUT_W){v[OUT_W-1]}}, v[OUT_W-1:0]};
  endfunction
  always_ff @(posedge clk) begin
    if (rst || accept) ovf_q <= 1'b0;
    else if (state_q == HORNER && (out_of_range(mac_a) || out_of_range(mac_b))) ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`endif
endmodule
